// File: rtl/button_event_arbiter_pkg.sv
// rtl/button_event_arbiter_pkg.sv - shared widths and edge direction constants for the button event arbiter
package button_event_arbiter_pkg;

    localparam logic EVENT_RISING  = 1'b1;
    localparam logic EVENT_FALLING = 1'b0;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - two-flop synchronizer, stability counter and debounced level for one input
module debounce_channel
    import button_event_arbiter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic edge_strobe,
    output logic edge_dir
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the raw pin into the clock domain
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q1 <= RESET_LEVEL;
            sync_q2 <= RESET_LEVEL;
        end else begin
            sync_q1 <= async_in;
            sync_q2 <= sync_q1;
        end
    end

    // The strobe fires in the cycle the new level is accepted, so the owner can latch it on the same edge
    assign edge_strobe = (sync_q2 != level) && (stable_cnt == CNT_LAST);
    assign edge_dir    = sync_q2 ? EVENT_RISING : EVENT_FALLING;

    // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES samples
    always_ff @(posedge clock) begin
        if (!reset) begin
            level      <= RESET_LEVEL;
            stable_cnt <= '0;
        end else if (sync_q2 != level) begin
            if (stable_cnt == CNT_LAST) begin
                level      <= sync_q2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - input conditioning plus round-robin event stream (optional EVENT_DROP_COUNT_EN)
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int CHANNELS        = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit RESET_LEVEL     = 1'b0,
    localparam int CH_W           = ch_width(CHANNELS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic [CHANNELS-1:0] level_out,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [CH_W-1:0]     event_channel,
    output logic                event_rising
`ifdef EVENT_DROP_COUNT_EN
    ,
    output logic [7:0]          drop_count
`endif
);

    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

    logic [CHANNELS-1:0] edge_strobe;
    logic [CHANNELS-1:0] edge_dir;
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] pending_dir;
    logic [CH_W-1:0]     rr_ptr;
    logic                slot_load;
    logic                grant_found;
    logic [CH_W-1:0]     grant_idx;
    logic                grant_dir;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL)
        ) u_debounce (
            .clock       (clock),
            .reset       (reset),
            .async_in    (async_in[g]),
            .level       (level_out[g]),
            .edge_strobe (edge_strobe[g]),
            .edge_dir    (edge_dir[g])
        );
    end

    assign slot_load = !event_valid || event_ready;

    // Round-robin pick: first pending at or above the pointer, otherwise the first pending below it
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_dir   = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_found && pending[i] && (i >= int'(rr_ptr))) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(i);
                grant_dir   = pending_dir[i];
            end
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (!grant_found && pending[i]) begin
                grant_found = 1'b1;
                grant_idx   = CH_W'(i);
                grant_dir   = pending_dir[i];
            end
        end
    end

    // One pending flag per channel; a fresh edge always wins over a grant and replaces the older direction
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending     <= '0;
            pending_dir <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (edge_strobe[i]) begin
                    pending[i]     <= 1'b1;
                    pending_dir[i] <= edge_dir[i];
                end else if (slot_load && grant_found && (grant_idx == CH_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Output slot refills whenever it is empty or being consumed; contents are frozen while stalled
    always_ff @(posedge clock) begin
        if (!reset) begin
            event_valid   <= 1'b0;
            event_channel <= '0;
            event_rising  <= 1'b0;
            rr_ptr        <= '0;
        end else if (slot_load) begin
            if (grant_found) begin
                event_valid   <= 1'b1;
                event_channel <= grant_idx;
                event_rising  <= grant_dir;
                rr_ptr        <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
            end else begin
                event_valid <= 1'b0;
            end
        end
    end

`ifdef EVENT_DROP_COUNT_EN
    logic [CHANNELS-1:0] drop_vec;
    logic [4:0]          drop_num;
    logic [9:0]          drop_sum;

    // An edge is coalesced when its channel already holds an undelivered event that is not leaving this cycle
    always_comb begin
        drop_vec = '0;
        drop_num = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            drop_vec[i] = edge_strobe[i] && pending[i] &&
                          !(slot_load && grant_found && (grant_idx == CH_W'(i)));
            drop_num = drop_num + 5'(drop_vec[i]);
        end
        drop_sum = 10'(drop_count) + 10'(drop_num);
    end

    // Saturating count of coalesced edges
    always_ff @(posedge clock) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop_sum > 10'd255) begin
            drop_count <= 8'd255;
        end else begin
            drop_count <= drop_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb/tb_button_event_arbiter.sv - randomized scoreboard bench for button_event_arbiter
module tb_button_event_arbiter;

    localparam int CH = 4;
    localparam int DB = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] async_in = '0;
    logic          event_ready = 1'b1;
    logic [CH-1:0] level_out;
    logic          event_valid;
    logic [1:0]    event_channel;
    logic          event_rising;
`ifdef EVENT_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    button_event_arbiter #(
        .CHANNELS        (CH),
        .DEBOUNCE_CYCLES (DB),
        .RESET_LEVEL     (1'b0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .async_in      (async_in),
        .level_out     (level_out),
        .event_valid   (event_valid),
        .event_ready   (event_ready),
        .event_channel (event_channel),
        .event_rising  (event_rising)
`ifdef EVENT_DROP_COUNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    typedef struct {
        int ch;
        int rise;
    } ev_t;

    ev_t          expq[$];
    logic [15:0]  m_hist [CH];
    logic [CH-1:0] m_level = '0;
    logic [CH-1:0] m_pend = '0;
    logic [CH-1:0] m_dir = '0;
    int           m_valid = 0;
    int           m_ptr = 0;
    int           m_drops = 0;

    // Reference: a level flips once the synchronized samples (pin delayed two clocks) have
    // disagreed with it for DB samples in a row; events queue per channel, newest direction wins.
    task automatic model_step();
        logic [CH-1:0] flip;
        int granted;
        int idx;
        bit all_diff;
        if (!reset) begin
            for (int c = 0; c < CH; c++) m_hist[c] = '0;
            m_level = '0;
            m_pend  = '0;
            m_dir   = '0;
            m_valid = 0;
            m_ptr   = 0;
            m_drops = 0;
            expq.delete();
            return;
        end
        flip = '0;
        for (int c = 0; c < CH; c++) begin
            m_hist[c] = {m_hist[c][14:0], async_in[c]};
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++)
                if (m_hist[c][j] == m_level[c]) all_diff = 1'b0;
            flip[c] = all_diff;
        end
        granted = -1;
        if (m_valid == 0 || event_ready) begin
            m_valid = 0;
            for (int k = 0; k < CH; k++) begin
                idx = (m_ptr + k) % CH;
                if (granted < 0 && m_pend[idx]) granted = idx;
            end
            if (granted >= 0) begin
                m_valid = 1;
                m_pend[granted] = 1'b0;
                m_ptr = (granted + 1) % CH;
                expq.push_back('{granted, int'(m_dir[granted])});
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (flip[c]) begin
                if (m_pend[c] && m_drops < 255) m_drops++;
                m_level[c] = ~m_level[c];
                m_pend[c]  = 1'b1;
                m_dir[c]   = m_level[c];
            end
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) m_hist[c] = '0;
        forever begin
            @(posedge clock);
            model_step();
        end
    end

    // Monitor: compare observable state each cycle and pop the scoreboard on each handshake
    initial begin
        bit hold_prev;
        int prev_ch;
        int prev_rise;
        ev_t exp_ev;
        hold_prev = 1'b0;
        prev_ch = 0;
        prev_rise = 0;
        forever begin
            @(negedge clock);
            check("level_out", int'(level_out), int'(m_level));
            check("event_valid", int'(event_valid), m_valid);
            if (hold_prev) begin
                check("stall_valid_held", int'(event_valid), 1);
                check("stall_channel_stable", int'(event_channel), prev_ch);
                check("stall_rising_stable", int'(event_rising), prev_rise);
            end
            if (event_valid && event_ready && reset) begin
                check("scoreboard_has_entry", int'(expq.size() > 0), 1);
                if (expq.size() > 0) begin
                    exp_ev = expq.pop_front();
                    check("event_channel", int'(event_channel), exp_ev.ch);
                    check("event_rising", int'(event_rising), exp_ev.rise);
                end
            end
            hold_prev = event_valid && !event_ready && reset;
            prev_ch   = int'(event_channel);
            prev_rise = int'(event_rising);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int n;
        int seen;
        int first_ch;
        int second_ch;
        int t0;
        int t1;
        int n_ch1;
        int n_ch2;
        int ch1_rise;

        reset = 1'b0;
        async_in = '0;
        event_ready = 1'b1;
        ticks(3);
        check("reset_level_out", int'(level_out), 0);
        check("reset_event_valid", int'(event_valid), 0);
        check("reset_event_channel", int'(event_channel), 0);
        check("reset_event_rising", int'(event_rising), 0);
        reset = 1'b1;
        ticks(2);

        // Stable press on ch2
        async_in[2] = 1'b1;
        n = -1;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            tick();
            if (level_out[2]) n = i;
        end
        check("ch2_level_latency", n, 2 + DB);
        tick();
        check("ch2_event_valid", int'(event_valid), 1);
        check("ch2_event_channel", int'(event_channel), 2);
        check("ch2_event_rising", int'(event_rising), 1);
        ticks(3);
        async_in[2] = 1'b0;
        ticks(12);

        // Short glitch on ch1
        async_in[1] = 1'b1;
        ticks(DB - 1);
        async_in[1] = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (event_valid) seen++;
        end
        check("glitch_no_event", seen, 0);
        check("glitch_level", int'(level_out), 0);

        // ch0 and ch3 together with pointer at 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        async_in = 4'b1001;
        seen = 0; first_ch = -1; second_ch = -1; t0 = 0; t1 = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (event_valid) begin
                if (seen == 0) begin first_ch = int'(event_channel); t0 = i; end
                else if (seen == 1) begin second_ch = int'(event_channel); t1 = i; end
                seen++;
            end
        end
        check("pair_event_count", seen, 2);
        check("pair_first_ch", first_ch, 0);
        check("pair_second_ch", second_ch, 3);
        check("pair_back_to_back", t1 - t0, 1);
        async_in = '0;
        ticks(12);

        // Stall: ch2 parked in the slot, ch1 rises then falls behind it
        event_ready = 1'b0;
        async_in[2] = 1'b1;
        ticks(8);
        async_in[1] = 1'b1;
        ticks(7);
        async_in[1] = 1'b0;
        ticks(7);
        check("stall_slot_valid", int'(event_valid), 1);
        check("stall_slot_channel", int'(event_channel), 2);
        event_ready = 1'b1;
        n_ch1 = 0; n_ch2 = 0; ch1_rise = -1;
        for (int i = 0; i < 10; i++) begin
            if (event_valid) begin
                if (event_channel == 2'd2) n_ch2++;
                if (event_channel == 2'd1) begin n_ch1++; ch1_rise = int'(event_rising); end
            end
            tick();
        end
        check("stall_ch2_pops", n_ch2, 1);
        check("coalesced_ch1_events", n_ch1, 1);
        check("coalesced_ch1_rising", ch1_rise, 0);
`ifdef EVENT_DROP_COUNT_EN
        check("drop_count_coalesce", int'(drop_count), 1);
`endif
        async_in[2] = 1'b0;
        ticks(12);

        // Reset with events queued
        event_ready = 1'b0;
        async_in = 4'b0111;
        ticks(8);
        async_in = '0;
        reset = 1'b0;
        tick();
        check("midreset_valid", int'(event_valid), 0);
        check("midreset_level", int'(level_out), 0);
        reset = 1'b1;
        event_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (event_valid) seen++;
        end
        check("midreset_no_events", seen, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 7) == 0) async_in[c] = ~async_in[c];
            event_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset = 1'b1;
        event_ready = 1'b1;
        ticks(30);
        check("drain_scoreboard_empty", expq.size(), 0);
        check("drain_valid_low", int'(event_valid), 0);
`ifdef EVENT_DROP_COUNT_EN
        check("drop_count_final", int'(drop_count), m_drops);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
